// File: rtl/pp_rr_grant_scheduler.sv
// ---------------------------------------------------------------------------
// pp_rr_grant_scheduler
//
// Round-robin grant scheduler over an N-entry request vector. A rotating
// pointer masks off requesters below it so the lowest-index-first search
// starts at the pointer and wraps to index 0 when nothing above it is
// requesting. One winning index is presented per valid/ready handshake.
// A fixed-priority mode (lowest index always wins) and a software pointer
// load are provided for configuration and debug.
//
// Ports:
//   clk         system clock, rising-edge active
//   rst_n       asynchronous active-low reset
//   en          scheduler enable; 0 blocks loading of new grants
//   rr_mode     1 = round-robin, 0 = fixed priority
//   req_vec     level-sensitive request bits, bit i = requester i
//   cfg_ptr_we  one-cycle strobe loading the pointer from cfg_ptr
//   cfg_ptr     pointer value to load
//   gnt_valid   a grant is presented
//   gnt_ready   consumer accepts the presented grant
//   gnt_idx     granted requester index
//   ptr         current search-start pointer
//   gnt_cnt     count of accepted grants, wraps at 2^CNT_W
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no grant presented; waiting for en with any request
// GRANT | gnt_idx presented and held until accepted
// ---------------------------------------------------------------------------
module pp_rr_grant_scheduler #(
    parameter int N     = 512,
    parameter int IDX_W = 9,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             rr_mode,
    input  logic [N-1:0]     req_vec,
    input  logic             cfg_ptr_we,
    input  logic [IDX_W-1:0] cfg_ptr,
    output logic             gnt_valid,
    input  logic             gnt_ready,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [IDX_W-1:0] ptr,
    output logic [CNT_W-1:0] gnt_cnt
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]       state;
    logic             accept;
    logic             any_req;
    logic [IDX_W-1:0] idx_inc;
    logic [IDX_W-1:0] ptr_use;
    logic [N-1:0]     search_mask;
    logic [N-1:0]     masked_req;
    logic [IDX_W-1:0] cand_idx;
    logic             load_grant;

    // Lowest set bit of v; returns 0 for an all-zero vector (callers gate
    // on any_req, so that value is never used).
    function automatic logic [IDX_W-1:0] lowest_set(input logic [N-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = IDX_W'(i);
            end
        end
        return r;
    endfunction

    assign gnt_valid = (state == ST_GRANT);
    assign accept    = gnt_valid && gnt_ready;
    assign any_req   = |req_vec;
    // Width-limited add gives the mod-N wrap (511 + 1 -> 0) for free.
    assign idx_inc   = gnt_idx + IDX_W'(1);

    // The pointer seen by this cycle's search already reflects a same-cycle
    // accept or software load, so back-to-back grants need no bubble.
    always_comb begin
        ptr_use = ptr;
        if (cfg_ptr_we) begin
            ptr_use = cfg_ptr;
        end else if (accept) begin
            ptr_use = idx_inc;
        end
    end

    // Thermometer mask: keep requesters at or above the search pointer.
    always_comb begin
        search_mask = '0;
        for (int i = 0; i < N; i++) begin
            search_mask[i] = (i >= int'(ptr_use));
        end
    end

    assign masked_req = req_vec & search_mask;

    always_comb begin
        cand_idx = lowest_set(req_vec);
        if (rr_mode && (|masked_req)) begin
            cand_idx = lowest_set(masked_req);
        end
    end

    // A new grant may load from IDLE, or in GRANT only when the held one
    // is being accepted this cycle.
    assign load_grant = en && any_req && (!gnt_valid || gnt_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            gnt_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_grant) begin
                        gnt_idx <= cand_idx;
                        state   <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (accept) begin
                        if (load_grant) begin
                            gnt_idx <= cand_idx;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Fixed-priority mode leaves the pointer alone on accept; only the
    // software load moves it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (cfg_ptr_we) begin
            ptr <= cfg_ptr;
        end else if (accept && rr_mode) begin
            ptr <= idx_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt <= '0;
        end else if (accept) begin
            gnt_cnt <= gnt_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pp_rr_grant_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pp_rr_grant_scheduler
//
// Table-driven bench for pp_rr_grant_scheduler. Each table row holds the
// inputs for one clock cycle and the outputs expected just after that
// cycle's rising edge. Expected rows are queued as stimulus is driven and
// popped for comparison once the DUT has clocked. Reset-related corner
// cases are written out by hand after the table.
// ---------------------------------------------------------------------------
module tb_pp_rr_grant_scheduler;

    localparam int N     = 512;
    localparam int IDX_W = 9;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             rr_mode;
    logic [N-1:0]     req_vec;
    logic             cfg_ptr_we;
    logic [IDX_W-1:0] cfg_ptr;
    logic             gnt_valid;
    logic             gnt_ready;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] gnt_cnt;

    int checks;
    int failures;

    typedef struct {
        logic             en;
        logic             rr;
        logic             we;
        logic [IDX_W-1:0] cfgp;
        logic             ready;
        logic [N-1:0]     req;
        logic             ev;
        logic [IDX_W-1:0] ei;
        logic [IDX_W-1:0] ep;
        logic [CNT_W-1:0] ec;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    pp_rr_grant_scheduler #(.N(N), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .rr_mode    (rr_mode),
        .req_vec    (req_vec),
        .cfg_ptr_we (cfg_ptr_we),
        .cfg_ptr    (cfg_ptr),
        .gnt_valid  (gnt_valid),
        .gnt_ready  (gnt_ready),
        .gnt_idx    (gnt_idx),
        .ptr        (ptr),
        .gnt_cnt    (gnt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] r2(input int a, input int b);
        logic [N-1:0] v;
        v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        return v;
    endfunction

    function automatic vec_t mk(input logic e, input logic rr, input logic we,
                                input int cfgp, input logic rdy,
                                input logic [N-1:0] req, input logic ev,
                                input int ei, input int ep, input int ec);
        vec_t v;
        v.en = e; v.rr = rr; v.we = we; v.cfgp = IDX_W'(cfgp);
        v.ready = rdy; v.req = req; v.ev = ev;
        v.ei = IDX_W'(ei); v.ep = IDX_W'(ep); v.ec = CNT_W'(ec);
        return v;
    endfunction

    task automatic chk(input string name, input int row, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=%0d expected=%0d", name, row, act, exp);
        end
    endtask

    task automatic add(input vec_t v);
        vecs.push_back(v);
    endtask

    initial begin
        vec_t v;
        vec_t e;
        bit   seen;

        checks = 0;
        failures = 0;

        // Round-robin between 3 and 7 with ready held high.
        add(mk(1,1,0,0,  1, r2(3,7),    1,  3,   0, 0));
        add(mk(1,1,0,0,  1, r2(3,7),    1,  7,   4, 1));
        add(mk(1,1,0,0,  1, r2(3,7),    1,  3,   8, 2));
        add(mk(1,1,0,0,  1, r2(3,7),    1,  7,   4, 3));
        add(mk(1,1,0,0,  1, r2(-1,-1),  0,  7,   8, 4));
        // Pointer load to 500, then wrap past 511.
        add(mk(1,1,1,500,0, r2(10,511), 1, 511, 500, 4));
        add(mk(1,1,0,0,  1, r2(10,511), 1, 10,   0, 5));
        add(mk(1,1,0,0,  1, r2(10,511), 1, 511, 11, 6));
        add(mk(1,1,0,0,  1, r2(-1,-1),  0, 511,  0, 7));
        // Backpressure: grant 5 held while request moves to 9.
        add(mk(1,1,0,0,  0, r2(5,-1),   1,  5,   0, 7));
        for (int i = 0; i < 4; i++) add(mk(1,1,0,0,0, r2(9,-1), 1, 5, 0, 7));
        add(mk(1,1,0,0,  1, r2(9,-1),   1,  9,   6, 8));
        add(mk(1,1,0,0,  1, r2(-1,-1),  0,  9,  10, 9));
        // Fixed priority with pointer at 50.
        add(mk(1,0,1,50, 0, r2(2,100),  1,  2,  50, 9));
        for (int i = 0; i < 3; i++) add(mk(1,0,0,0,1, r2(2,100), 1, 2, 50, 10 + i));
        add(mk(1,0,0,0,  1, r2(-1,-1),  0,  2,  50, 13));
        // Pointer load colliding with the accept of 40.
        add(mk(1,1,0,0,  0, r2(40,-1),  1, 40,  50, 13));
        add(mk(1,1,1,200,1, r2(41,300), 1, 300, 200, 14));
        add(mk(1,1,0,0,  1, r2(-1,-1),  0, 300, 301, 15));
        // Enable low: nothing loads; a held grant can still be accepted.
        add(mk(0,1,0,0,  1, r2(-1,-1),  0, 300, 301, 15));
        add(mk(0,1,0,0,  1, r2(3,-1),   0, 300, 301, 15));
        add(mk(1,1,0,0,  0, r2(1,-1),   1,  1, 301, 15));
        add(mk(0,1,0,0,  1, r2(1,-1),   0,  1,   2, 16));
        // Grant left pending for the mid-grant reset below.
        add(mk(1,1,0,0,  0, r2(6,-1),   1,  6,   2, 16));

        rst_n = 1'b0; en = 1'b0; rr_mode = 1'b1; req_vec = '0;
        cfg_ptr_we = 1'b0; cfg_ptr = '0; gnt_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", -1, int'(gnt_valid), 0);
        chk("rst_idx",   -1, int'(gnt_idx),   0);
        chk("rst_ptr",   -1, int'(ptr),       0);
        chk("rst_cnt",   -1, int'(gnt_cnt),   0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < vecs.size(); r++) begin
            v = vecs[r];
            @(negedge clk);
            en = v.en; rr_mode = v.rr; cfg_ptr_we = v.we; cfg_ptr = v.cfgp;
            gnt_ready = v.ready; req_vec = v.req;
            exp_q.push_back(v);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            chk("gnt_valid", r, int'(gnt_valid), int'(e.ev));
            chk("gnt_idx",   r, int'(gnt_idx),   int'(e.ei));
            chk("ptr",       r, int'(ptr),       int'(e.ep));
            chk("gnt_cnt",   r, int'(gnt_cnt),   int'(e.ec));
        end

        // Asynchronous reset in the middle of a cycle, away from any edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", -2, int'(gnt_valid), 0);
        chk("arst_idx",   -2, int'(gnt_idx),   0);
        chk("arst_ptr",   -2, int'(ptr),       0);
        chk("arst_cnt",   -2, int'(gnt_cnt),   0);

        // Recovery after reset: a fresh request is granted within a bounded wait.
        @(negedge clk);
        rst_n = 1'b1; en = 1'b1; rr_mode = 1'b1; cfg_ptr_we = 1'b0;
        gnt_ready = 1'b0; req_vec = r2(3, 200);
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (gnt_valid) seen = 1'b1;
        end
        chk("recover_valid", -3, int'(seen), 1);
        chk("recover_idx",   -3, int'(gnt_idx), 3);

        @(negedge clk);
        en = 1'b0; req_vec = '0; gnt_ready = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pp_rr_grant_scheduler.md
Name: pp_rr_grant_scheduler

Overview:
- Round-robin grant scheduler for a 512-entry request vector; issues one winning index per handshake.
- Builds on the 512-to-9 lowest-index-first priority encode: a rotating pointer masks the request vector, so search starts at the pointer and wraps around.
- Sits between request-collection logic (e.g. queue-not-empty flags) and the downstream consumer.
- Supports a fixed-priority mode and software pointer load for configuration/debug.

Parameters:
- N, 512, number of requesters; power of two.
- IDX_W, 9, index width, equal to log2(N).
- CNT_W, 16, width of the grant counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scheduler enable; when 0, no new grant is loaded.
- rr_mode  in  1  1 = round-robin; 0 = fixed priority, lowest index wins and pointer is ignored.
- req_vec  in  N  request bits, level-sensitive; bit i = requester i.
- cfg_ptr_we  in  1  one-cycle strobe; loads the pointer from cfg_ptr.
- cfg_ptr  in  IDX_W  pointer value to load.
- gnt_valid  out  1  a grant is presented.
- gnt_ready  in  1  consumer accepts the grant.
- gnt_idx  out  IDX_W  granted requester index.
- ptr  out  IDX_W  current search-start pointer.
- gnt_cnt  out  CNT_W  count of accepted grants; wraps at 2^CNT_W.

Behaviour:
- Reset (async assert, sync-to-clk deassert handled upstream): gnt_valid=0, gnt_idx=0, ptr=0, gnt_cnt=0, state=IDLE.
- Search vector:
  - masked = req_vec & ~((1<<p)-1), where p = pointer used this cycle.
  - If masked is nonzero, candidate = lowest set bit of masked.
  - Otherwise candidate = lowest set bit of req_vec (wrap).
  - If rr_mode=0, candidate = lowest set bit of req_vec.
  - any_req = |req_vec.
- Pointer used this cycle: p = cfg_ptr if cfg_ptr_we, else (gnt_idx+1) mod N if an accept happens this cycle, else ptr.
- State IDLE (gnt_valid=0):
  - If en && any_req: register candidate into gnt_idx, set gnt_valid=1, go to GRANT.
  - Latency from first request to gnt_valid is 1 cycle.
- State GRANT (gnt_valid=1):
  - gnt_idx is held stable while gnt_ready=0.
  - Dropping the request bit does not retract the grant.
  - cfg_ptr_we does not alter the held grant.
  - On accept (gnt_valid && gnt_ready):
    - If rr_mode=1: ptr <= (gnt_idx+1) mod N, so 511 wraps to 0.
    - gnt_cnt <= gnt_cnt+1.
    - If en && any_req this cycle: load the next candidate, computed with the post-accept pointer, and stay in GRANT. This gives back-to-back grants with no bubble.
    - Otherwise gnt_valid <= 0 and return to IDLE.
- rr_mode=0: ptr updates only via cfg_ptr_we, never on accept.
- cfg_ptr_we on the same cycle as an accept: the cfg_ptr value wins for both ptr and the search of the following grant.
- en=0 in GRANT: the held grant can still be accepted; no new grant loads afterwards.
- Combinational path: gnt_ready feeds the pointer, which feeds the mask, the encoder and the gnt_idx register. This is a single-cycle 512-bit search path; no pipelining inside the block.
- Reset mid-grant: all outputs return to reset values immediately; the pending grant is lost.

Test Plan:
- Reset, then req_vec bits {3,7} set, gnt_ready=1 throughout:
  - grants are 3, 7, 3, 7…
  - first gnt_valid appears 1 cycle after the request.
  - ptr is 4 after the first accept.
  - gnt_cnt increments by 1 each cycle.
- Wrap: cfg_ptr_we with cfg_ptr=500, req bits {10,511}:
  - grants are 511, then 10.
  - ptr goes 500 → 0 (after 511) → 11.
- Backpressure: req bit 5 set, gnt_ready=0 for 4 cycles while req is dropped and bit 9 raised:
  - gnt_idx stays 5 with gnt_valid=1.
  - after the accept, the next grant is 9.
- Fixed mode rr_mode=0, req bits {2,100}, ptr=50:
  - every grant is 2.
  - ptr stays 50.
- Simultaneous cfg_ptr_we=1 (cfg_ptr=200) and accept of idx 40, req bits {41,300}:
  - next grant is 300.
  - ptr=200.
- en=0 and req all-zero:
  - gnt_valid stays 0.
  - rst_n pulse mid-GRANT clears gnt_valid, gnt_idx, ptr and gnt_cnt to 0 asynchronously.
